// File: rtl/gates7_pkg.sv
// Shared types and golden model for the seven-output gate block checker.
package gates7_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSample,
    StDone
  } state_e;

  localparam int unsigned NVEC = 4;

  // Bit positions of each gate output within f.
  localparam int unsigned AND_B  = 6;
  localparam int unsigned OR_B   = 5;
  localparam int unsigned NOT_B  = 4;
  localparam int unsigned NAND_B = 3;
  localparam int unsigned NOR_B  = 2;
  localparam int unsigned XOR_B  = 1;
  localparam int unsigned XNOR_B = 0;

  function automatic logic [6:0] expected(input logic a, input logic b);
    logic [6:0] y;
    y         = '0;
    y[AND_B]  = a & b;
    y[OR_B]   = a | b;
    y[NOT_B]  = ~a;
    y[NAND_B] = ~(a & b);
    y[NOR_B]  = ~(a | b);
    y[XOR_B]  = a ^ b;
    y[XNOR_B] = ~(a ^ b);
    return y;
  endfunction

endpackage

// File: rtl/gates7_expect.sv
// Combinational golden model of the gate block, reusable outside the checker.
module gates7_expect
  import gates7_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  output logic [6:0] y_o
);

  // Golden output for the current stimulus.
  always_comb begin
    y_o = expected(a_i, b_i);
  end

endmodule

// File: rtl/gates7_vector_checker.sv
// Sequences the four a/b vectors into the gate block, waits SETTLE cycles per
// vector, compares f against the golden model and accumulates results.
module gates7_vector_checker
  import gates7_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic [6:0] f,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [6:0] err_mask,
  output logic [1:0] first_fail
);

  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE - 1);
  localparam logic [1:0] LastVec = 2'(NVEC - 1);

  state_e          state_q, state_d;
  logic [1:0]      v_q, v_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            a_q, a_d, b_q, b_d;
  logic [2:0]      err_count_q, err_count_d;
  logic [6:0]      err_mask_q, err_mask_d;
  logic [1:0]      first_fail_q, first_fail_d;
  logic [6:0]      exp_vec;
  logic [6:0]      diff;

  gates7_expect u_expect (
    .a_i (v_q[0]),
    .b_i (v_q[1]),
    .y_o (exp_vec)
  );

  assign diff = f ^ exp_vec;

  // Next-state: sequencing, settle counting and result accumulation.
  always_comb begin
    state_d      = state_q;
    v_d          = v_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    err_count_d  = err_count_q;
    err_mask_d   = err_mask_q;
    first_fail_d = first_fail_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          err_count_d  = '0;
          err_mask_d   = '0;
          first_fail_d = '0;
          v_d          = '0;
          a_d          = 1'b0;
          b_d          = 1'b0;
          cnt_d        = CntLoad;
          state_d      = StDrive;
        end
      end
      StDrive: begin
        if (cnt_q == '0) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StSample: begin
        if (diff != '0) begin
          err_count_d = err_count_q + 3'd1;
          err_mask_d  = err_mask_q | diff;
          // Only the first failing vector is recorded.
          if (err_count_q == '0) begin
            first_fail_d = v_q;
          end
        end
        if (v_q == LastVec) begin
          a_d     = 1'b0;
          b_d     = 1'b0;
          state_d = StDone;
        end else begin
          v_d     = v_q + 2'd1;
          a_d     = v_d[0];
          b_d     = v_d[1];
          cnt_d   = CntLoad;
          state_d = StDrive;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers with asynchronous clear.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= StIdle;
      v_q          <= '0;
      cnt_q        <= '0;
      a_q          <= 1'b0;
      b_q          <= 1'b0;
      err_count_q  <= '0;
      err_mask_q   <= '0;
      first_fail_q <= '0;
    end else begin
      state_q      <= state_d;
      v_q          <= v_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      err_count_q  <= err_count_d;
      err_mask_q   <= err_mask_d;
      first_fail_q <= first_fail_d;
    end
  end

  // Outputs decode directly from registers, so they are glitch-free.
  always_comb begin
    a          = a_q;
    b          = b_q;
    busy       = (state_q == StDrive) || (state_q == StSample);
    done       = (state_q == StDone);
    pass       = done && (err_count_q == '0);
    err_count  = err_count_q;
    err_mask   = err_mask_q;
    first_fail = first_fail_q;
  end

endmodule

// File: tb/tb_gates7_vector_checker.sv
// Randomized self-checking bench: two checkers (SETTLE=1 and SETTLE=3) each
// drive a faultable gate-block model; results are predicted from fault tables.
module tb_gates7_vector_checker;

  logic clk = 1'b0;
  logic clrn;
  logic start;

  logic       a1, b1, busy1, done1, pass1;
  logic [6:0] f1, err_mask1;
  logic [2:0] err_count1;
  logic [1:0] first_fail1;

  logic       a3, b3, busy3, done3, pass3;
  logic [6:0] f3, err_mask3;
  logic [2:0] err_count3;
  logic [1:0] first_fail3;

  // 0: correct, 1: f_xor stuck 0, 2: f_not tied to a, 3: random flip table
  int          mode;
  logic [27:0] rflip;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic logic [6:0] golden(input logic a, input logic b);
    return {a & b, a | b, ~a, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
  endfunction

  function automatic logic [6:0] gate_out(input logic a, input logic b, input int m,
                                          input logic [27:0] fl);
    logic [6:0] y;
    logic [1:0] idx;
    y   = golden(a, b);
    idx = {b, a};
    case (m)
      1:       y[1] = 1'b0;
      2:       y[4] = a;
      3:       y = y ^ fl[7*idx+:7];
      default: ;
    endcase
    return y;
  endfunction

  assign f1 = gate_out(a1, b1, mode, rflip);
  assign f3 = gate_out(a3, b3, mode, rflip);

  gates7_vector_checker #(.SETTLE(1)) dut1 (
    .clk        (clk),
    .clrn       (clrn),
    .start      (start),
    .a          (a1),
    .b          (b1),
    .f          (f1),
    .busy       (busy1),
    .done       (done1),
    .pass       (pass1),
    .err_count  (err_count1),
    .err_mask   (err_mask1),
    .first_fail (first_fail1)
  );

  gates7_vector_checker #(.SETTLE(3)) dut3 (
    .clk        (clk),
    .clrn       (clrn),
    .start      (start),
    .a          (a3),
    .b          (b3),
    .f          (f3),
    .busy       (busy3),
    .done       (done3),
    .pass       (pass3),
    .err_count  (err_count3),
    .err_mask   (err_mask3),
    .first_fail (first_fail3)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " dut1"}, {a1, b1, busy1, done1, pass1, err_count1, err_mask1, first_fail1},
             '0);
    check_eq({tag, " dut3"}, {a3, b3, busy3, done3, pass3, err_count3, err_mask3, first_fail3},
             '0);
  endtask

  // Runs one full sequence and compares against the fault-table prediction.
  task automatic do_run(input int m, input bit inject, input bit chk_clear);
    logic [6:0]  d;
    logic [1:0]  vv;
    int          e_cnt;
    logic [6:0]  e_mask;
    logic [1:0]  e_ff;
    logic [33:0] tr, etr;
    int          t1, t3;
    mode   = m;
    e_cnt  = 0;
    e_mask = '0;
    e_ff   = '0;
    for (int v = 0; v < 4; v++) begin
      vv = 2'(v);
      d  = gate_out(vv[0], vv[1], m, rflip) ^ golden(vv[0], vv[1]);
      if (d != '0) begin
        if (e_cnt == 0) e_ff = vv;
        e_cnt++;
        e_mask |= d;
      end
    end
    etr = '0;
    for (int k = 0; k < 16; k++) etr[2*k+:2] = 2'(k / 4);

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (chk_clear) begin
      check_eq("restart clears", {done1, busy1, err_count1, err_mask1, first_fail1},
               {1'b0, 1'b1, 12'h0});
    end
    tr     = '0;
    tr[1:0] = {b3, a3};
    t1 = 0;
    t3 = 0;
    for (int k = 1; k <= 40 && (t1 == 0 || t3 == 0); k++) begin
      @(posedge clk);
      #1;
      if (inject) begin
        if (k == 4) start = 1'b1;
        else if (k == 5) start = 1'b0;
      end
      if (k <= 16) tr[2*k+:2] = {b3, a3};
      if (done1 && t1 == 0) t1 = k;
      if (done3 && t3 == 0) t3 = k;
    end

    check_eq("latency1", t1, 8);
    check_eq("latency3", t3, 16);
    check_eq("trace3", tr, etr);
    check_eq("pass1", pass1, e_cnt == 0);
    check_eq("pass3", pass3, e_cnt == 0);
    check_eq("err_count1", err_count1, e_cnt);
    check_eq("err_count3", err_count3, e_cnt);
    check_eq("err_mask1", err_mask1, e_mask);
    check_eq("err_mask3", err_mask3, e_mask);
    if (e_cnt != 0) begin
      check_eq("first_fail1", first_fail1, e_ff);
      check_eq("first_fail3", first_fail3, e_ff);
    end
    check_eq("idle ab busy1", {a1, b1, busy1}, 3'b000);
    check_eq("idle ab busy3", {a3, b3, busy3}, 3'b000);
  endtask

  initial begin
    clrn  = 1'b0;
    start = 1'b0;
    mode  = 0;
    rflip = '0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    clrn = 1'b1;

    do_run(0, 1'b0, 1'b0);   // clean run
    do_run(1, 1'b0, 1'b0);   // f_xor stuck 0: v1,v2 fail
    do_run(2, 1'b0, 1'b1);   // f_not = a: all fail; also restart from DONE
    do_run(0, 1'b1, 1'b1);   // start during DRIVE of v2 ignored

    // Asynchronous clear during SAMPLE of v=1 on the SETTLE=1 checker.
    mode = 2;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_eq("pre-clear err_count1", err_count1, 3'd1);
    clrn = 1'b0;
    #1;
    check_reset_outputs("async clear");
    @(negedge clk);
    clrn = 1'b1;
    do_run(0, 1'b0, 1'b0);

    // Random fault tables, some with random start pulses while busy.
    repeat (12) begin
      for (int v = 0; v < 4; v++) begin
        rflip[7*v+:7] = ($urandom_range(0, 2) == 0) ? 7'h00 : 7'($urandom);
      end
      do_run(3, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
